dmem_ctrl: RTL and testbench

Handshaked data-memory responder for the RV32I pipeline. It accepts load/store requests from a bus initiator over a valid/ready channel, inserts a fixed number of wait states, applies byte-enabled writes or captures read words, and returns one response per request over a second valid/ready channel. It is the memory-side counterpart of the core's data port and is used in multi-cycle and stalled-pipeline configurations.

---
 rtl/dmem_pkg.sv | 19 +
 rtl/dmem_ram.sv | 38 +++
 rtl/dmem_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_dmem_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// -----------------------------------------------------------------------------
// dmem_pkg
// Shared types and constants for the dmem_ctrl data-memory responder.
//   state_t     : controller FSM states (idle / wait states / response)
//   WORD_BYTES  : bytes per memory word (one write enable per byte lane)
//   CNT_W       : width of the wait-state counter (covers 0..15 wait cycles)
// -----------------------------------------------------------------------------
package dmem_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   localparam int WORD_BYTES = 4;
   localparam int CNT_W      = 4;

endpackage

// File: rtl/dmem_ram.sv
// -----------------------------------------------------------------------------
// dmem_ram
// DEPTH_WORDS x 32-bit storage built from one byte-wide array per lane, so each
// lane has its own write enable. Synchronous write, asynchronous read.
// Contents are never reset.
// Ports:
//   clk    in   clock
//   we     in   per-byte write enables (bit i writes wdata[8i+7:8i])
//   addr   in   word index, shared by read and write
//   wdata  in   write data
//   rdata  out  word currently stored at addr
// -----------------------------------------------------------------------------
module dmem_ram
   import dmem_pkg::*;
#(
   parameter int DEPTH_WORDS = 1024
) (
   input  logic                           clk,
   input  logic [WORD_BYTES-1:0]          we,
   input  logic [$clog2(DEPTH_WORDS)-1:0] addr,
   input  logic [8*WORD_BYTES-1:0]        wdata,
   output logic [8*WORD_BYTES-1:0]        rdata
);

   genvar gi;
   for (gi = 0; gi < WORD_BYTES; gi++) begin : g_lane
      logic [7:0] lane_mem [DEPTH_WORDS];

      always_ff @(posedge clk) begin
         if (we[gi]) begin
            lane_mem[addr] <= wdata[8*gi +: 8];
         end
      end

      assign rdata[8*gi +: 8] = lane_mem[addr];
   end

endmodule

// File: rtl/dmem_ctrl.sv
// -----------------------------------------------------------------------------
// dmem_ctrl
// Handshaked load/store responder: accepts one request, waits WAIT_CYCLES
// cycles, performs the byte-enabled store or word load, then holds a response
// until the initiator takes it. Strictly one transaction outstanding.
// Optional macro DMEM_CTRL_ERR_EN: adds rsp_err and flags out-of-range word
// indices and stores with no byte enables (no write, zero data). Without it,
// word indices wrap modulo DEPTH_WORDS.
// Ports:
//   clk, clr_n                clock, async active-low reset
//   req_valid/req_ready       request handshake (req_ready is registered)
//   req_we/addr/wdata/be      request payload (addr bits [1:0] ignored)
//   rsp_valid/rsp_ready       response handshake
//   rsp_rdata                 load word, 0 for stores
//   rsp_err                   access error (only with DMEM_CTRL_ERR_EN)
// -----------------------------------------------------------------------------
module dmem_ctrl
   import dmem_pkg::*;
#(
   parameter int DEPTH_WORDS = 1024,
   parameter int WAIT_CYCLES = 1
) (
   input  logic        clk,
   input  logic        clr_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [3:0]  req_be,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata
`ifdef DMEM_CTRL_ERR_EN
   ,
   output logic        rsp_err
`endif
);

   localparam int               AW        = $clog2(DEPTH_WORDS);
   localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(WAIT_CYCLES);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             req_ready_q, req_ready_d;
   logic             rsp_valid_q, rsp_valid_d;
   logic [31:0]      rsp_rdata_q, rsp_rdata_d;
   logic             we_q, we_d;
   logic [AW-1:0]    idx_q, idx_d;
   logic [31:0]      wdata_q, wdata_d;
   logic [3:0]       be_q, be_d;

   logic             accept;
   logic             do_access;
   logic             acc_we;
   logic [AW-1:0]    acc_idx;
   logic [31:0]      acc_wdata;
   logic [3:0]       acc_be;
   logic             acc_err;
   logic [3:0]       ram_we;
   logic [31:0]      ram_rdata;

   // Address bits outside the word index only matter to the error check.
   logic unused_addr_bits;
   assign unused_addr_bits = ^req_addr;

   assign accept = (state_q == ST_IDLE) && req_valid && req_ready_q;

   // With zero wait states the access happens on the acceptance edge, so the
   // live request is used; otherwise the access comes from the latches.
   assign do_access = (WAIT_CYCLES == 0) ? accept
                                         : ((state_q == ST_WAIT) && (cnt_q == CNT_W'(1)));
   assign acc_we    = (state_q == ST_IDLE) ? req_we             : we_q;
   assign acc_idx   = (state_q == ST_IDLE) ? req_addr[AW+1:2]   : idx_q;
   assign acc_wdata = (state_q == ST_IDLE) ? req_wdata          : wdata_q;
   assign acc_be    = (state_q == ST_IDLE) ? req_be             : be_q;

`ifdef DMEM_CTRL_ERR_EN
   logic req_err;
   logic err_q, err_d;
   logic rsp_err_q, rsp_err_d;

   assign req_err = ((req_addr[31:2] >> AW) != 30'd0) || (req_we && (req_be == 4'd0));
   assign acc_err = (state_q == ST_IDLE) ? req_err : err_q;

   always_comb begin
      err_d     = accept ? req_err : err_q;
      rsp_err_d = do_access ? acc_err : rsp_err_q;
   end

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         err_q     <= 1'b0;
         rsp_err_q <= 1'b0;
      end else begin
         err_q     <= err_d;
         rsp_err_q <= rsp_err_d;
      end
   end

   assign rsp_err = rsp_err_q;
`else
   assign acc_err = 1'b0;
`endif

   // State register and all datapath flops
   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         req_ready_q <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         we_q        <= 1'b0;
         idx_q       <= '0;
         wdata_q     <= '0;
         be_q        <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         req_ready_q <= req_ready_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         we_q        <= we_d;
         idx_q       <= idx_d;
         wdata_q     <= wdata_d;
         be_q        <= be_d;
      end
   end

   // Next-state logic and wait counter
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               if (WAIT_CYCLES == 0) begin
                  state_d = ST_RESP;
               end else begin
                  state_d = ST_WAIT;
                  cnt_d   = WAIT_INIT;
               end
            end
         end
         ST_WAIT: begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
               state_d = ST_RESP;
            end
         end
         ST_RESP: begin
            if (rsp_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Outputs, request latches and memory access
   always_comb begin
      // Handshake outputs are registered copies of the next state.
      req_ready_d = (state_d == ST_IDLE);
      rsp_valid_d = (state_d == ST_RESP);
      rsp_rdata_d = rsp_rdata_q;
      we_d        = we_q;
      idx_d       = idx_q;
      wdata_d     = wdata_q;
      be_d        = be_q;
      ram_we      = '0;
      if (accept) begin
         we_d    = req_we;
         idx_d   = req_addr[AW+1:2];
         wdata_d = req_wdata;
         be_d    = req_be;
      end
      if (do_access) begin
         rsp_rdata_d = (acc_we || acc_err) ? 32'd0 : ram_rdata;
         if (acc_we && !acc_err) begin
            ram_we = acc_be;
         end
      end
   end

   dmem_ram #(
      .DEPTH_WORDS (DEPTH_WORDS)
   ) u_ram (
      .clk   (clk),
      .we    (ram_we),
      .addr  (acc_idx),
      .wdata (acc_wdata),
      .rdata (ram_rdata)
   );

   assign req_ready = req_ready_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dmem_ctrl
// Self-checking bench for dmem_ctrl (DEPTH_WORDS=64, WAIT_CYCLES=1): directed
// vector table, reset and back-pressure sequences, then random traffic checked
// against a word-array reference model. Honours DMEM_CTRL_ERR_EN.
// -----------------------------------------------------------------------------
module tb_dmem_ctrl;

   localparam int DEPTH = 64;
   localparam int WAITC = 1;

   logic        clk;
   logic        clr_n;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [3:0]  req_be;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;
`ifdef DMEM_CTRL_ERR_EN
   logic        rsp_err;
`endif

   int checks   = 0;
   int failures = 0;

   logic [31:0] model_mem [DEPTH];

   dmem_ctrl #(
      .DEPTH_WORDS (DEPTH),
      .WAIT_CYCLES (WAITC)
   ) dut (
      .clk       (clk),
      .clr_n     (clr_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_we    (req_we),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .req_be    (req_be),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_rdata (rsp_rdata)
`ifdef DMEM_CTRL_ERR_EN
      ,
      .rsp_err   (rsp_err)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   function automatic logic cur_err();
`ifdef DMEM_CTRL_ERR_EN
      return rsp_err;
`else
      return 1'b0;
`endif
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%08h required=%08h", name, act, exp);
      end
   endtask

   // Reference model: word array, error rules and wrap computed from the
   // address arithmetic directly.
   function automatic void model_txn(input logic we, input logic [31:0] addr,
                                     input logic [31:0] wdata, input logic [3:0] be,
                                     output logic [31:0] rd, output logic err);
      int unsigned idx;
      idx = 32'(addr[31:2]);
      err = 1'b0;
`ifdef DMEM_CTRL_ERR_EN
      err = (idx >= DEPTH) || (we && (be == 4'd0));
`endif
      idx = idx % DEPTH;
      rd  = 32'd0;
      if (!err) begin
         if (we) begin
            for (int b = 0; b < 4; b++) begin
               if (be[b]) model_mem[idx][8*b +: 8] = wdata[8*b +: 8];
            end
         end else begin
            rd = model_mem[idx];
         end
      end
   endfunction

   // One full transaction. During the back-pressure hold an optional stray
   // store is presented, which must not be accepted.
   task automatic do_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] be, input int hold, input logic stray,
                         input logic [31:0] stray_addr,
                         output logic [31:0] rdata, output logic err);
      int n;
      req_we    = we;
      req_addr  = addr;
      req_wdata = wdata;
      req_be    = be;
      req_valid = 1'b1;
      n = 0;
      while (!req_ready && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      check("req_ready_before_accept", 32'(req_ready), 32'd1);
      @(posedge clk); #1;
      req_valid = 1'b0;
      check("req_ready_low_after_accept", 32'(req_ready), 32'd0);
      n = 0;
      while (!rsp_valid && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      check("rsp_latency", 32'(n), 32'(WAITC));
      rdata = rsp_rdata;
      err   = cur_err();
      if (stray) begin
         req_we    = 1'b1;
         req_addr  = stray_addr;
         req_wdata = 32'h5A5A5A5A;
         req_be    = 4'hF;
         req_valid = 1'b1;
      end
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
         check("bp_rsp_rdata", rsp_rdata, rdata);
         check("bp_req_ready", 32'(req_ready), 32'd0);
      end
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      req_valid = 1'b0;
      check("rsp_valid_after_hs", 32'(rsp_valid), 32'd0);
      check("req_ready_after_hs", 32'(req_ready), 32'd1);
      $display("txn we=%0d addr=%08h wdata=%08h be=%h rdata=%08h err=%0d",
               we, addr, wdata, be, rdata, err);
   endtask

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  be;
      logic [31:0] exp_rdata;
      logic        exp_err;
   } vec_t;

   vec_t vecs [16];

   initial begin
      logic [31:0] rd, exp_rd, old_val;
      logic        er, exp_er;
      logic        seen;
      logic        we_r;
      logic [31:0] addr_r, wd_r;
      logic [3:0]  be_r;
      int          n, r;

      clr_n     = 1'b0;
      req_valid = 1'b0;
      req_we    = 1'b0;
      req_addr  = '0;
      req_wdata = '0;
      req_be    = '0;
      rsp_ready = 1'b0;

      // Reset values and release
      repeat (3) @(posedge clk);
      #1;
      check("reset_req_ready", 32'(req_ready), 32'd0);
      check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
      check("reset_rsp_rdata", rsp_rdata, 32'd0);
      check("reset_rsp_err", 32'(cur_err()), 32'd0);
      clr_n = 1'b1;
      #2;
      check("release_req_ready_pre_edge", 32'(req_ready), 32'd0);
      @(posedge clk); #1;
      check("release_req_ready", 32'(req_ready), 32'd1);
      check("release_rsp_valid", 32'(rsp_valid), 32'd0);

      // Fill the whole memory so every later load has a known expectation
      for (int i = 0; i < DEPTH; i++) begin
         wd_r = $urandom;
         model_txn(1'b1, 32'(i * 4), wd_r, 4'hF, exp_rd, exp_er);
         do_txn(1'b1, 32'(i * 4), wd_r, 4'hF, 0, 1'b0, 32'd0, rd, er);
         check("fill_rdata", rd, 32'd0);
         check("fill_err", 32'(er), 32'd0);
      end

      // Directed vectors
      vecs[0]  = '{1'b1, 32'h0000_0010, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0};
      vecs[1]  = '{1'b0, 32'h0000_0010, 32'h0,        4'h0, 32'hDEADBEEF, 1'b0};
      vecs[2]  = '{1'b1, 32'h0000_0014, 32'h11223344, 4'hF, 32'h0, 1'b0};
      vecs[3]  = '{1'b1, 32'h0000_0014, 32'h0000AB00, 4'b0010, 32'h0, 1'b0};
      vecs[4]  = '{1'b0, 32'h0000_0014, 32'h0,        4'h0, 32'h1122AB44, 1'b0};
      vecs[5]  = '{1'b0, 32'h0000_0013, 32'h0,        4'h0, 32'hDEADBEEF, 1'b0};
      vecs[6]  = '{1'b1, 32'h0000_0000, 32'hCAFEF00D, 4'hF, 32'h0, 1'b0};
      vecs[9]  = '{1'b0, 32'h0000_0014, 32'h0,        4'h0, 32'h1122AB44, 1'b0};
      vecs[12] = '{1'b1, 32'h0000_0018, 32'h00000000, 4'hF, 32'h0, 1'b0};
      vecs[13] = '{1'b1, 32'h0000_0018, 32'hA1B2C3D4, 4'b1001, 32'h0, 1'b0};
      vecs[14] = '{1'b0, 32'h0000_0018, 32'h0,        4'h0, 32'hA10000D4, 1'b0};
`ifdef DMEM_CTRL_ERR_EN
      vecs[7]  = '{1'b0, 32'h0000_0100, 32'h0,        4'h0, 32'h0, 1'b1};
      vecs[8]  = '{1'b1, 32'h0000_0014, 32'hFFFFFFFF, 4'h0, 32'h0, 1'b1};
      vecs[10] = '{1'b1, 32'h0000_0100, 32'h12345678, 4'hF, 32'h0, 1'b1};
      vecs[11] = '{1'b0, 32'h0000_0000, 32'h0,        4'h0, 32'hCAFEF00D, 1'b0};
      vecs[15] = '{1'b0, 32'h1000_0010, 32'h0,        4'h0, 32'h0, 1'b1};
`else
      vecs[7]  = '{1'b0, 32'h0000_0100, 32'h0,        4'h0, 32'hCAFEF00D, 1'b0};
      vecs[8]  = '{1'b1, 32'h0000_0014, 32'hFFFFFFFF, 4'h0, 32'h0, 1'b0};
      vecs[10] = '{1'b1, 32'h0000_0100, 32'h12345678, 4'hF, 32'h0, 1'b0};
      vecs[11] = '{1'b0, 32'h0000_0000, 32'h0,        4'h0, 32'h12345678, 1'b0};
      vecs[15] = '{1'b0, 32'h1000_0010, 32'h0,        4'h0, 32'hDEADBEEF, 1'b0};
`endif
      for (int i = 0; i < 16; i++) begin
         model_txn(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be, exp_rd, exp_er);
         do_txn(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be, i % 3, 1'b0, 32'd0, rd, er);
         check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
         check($sformatf("vec%0d_err", i), 32'(er), 32'(vecs[i].exp_err));
      end

      // Back-pressure for 5 cycles with a stray store to 0x30 waiting
      do_txn(1'b0, 32'h10, 32'h0, 4'h0, 5, 1'b1, 32'h30, rd, er);
      check("bp_load_rdata", rd, 32'hDEADBEEF);
      model_txn(1'b0, 32'h30, 32'h0, 4'h0, exp_rd, exp_er);
      do_txn(1'b0, 32'h30, 32'h0, 4'h0, 0, 1'b0, 32'd0, rd, er);
      check("stray_not_written", rd, exp_rd);

      // Reset during the wait state of a store to 0x20
      model_txn(1'b0, 32'h20, 32'h0, 4'h0, old_val, exp_er);
      req_we    = 1'b1;
      req_addr  = 32'h20;
      req_wdata = ~old_val;
      req_be    = 4'hF;
      req_valid = 1'b1;
      n = 0;
      while (!req_ready && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      check("midrst_ready", 32'(req_ready), 32'd1);
      @(posedge clk); #1;
      req_valid = 1'b0;
      clr_n     = 1'b0;
      #1;
      check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("midrst_req_ready", 32'(req_ready), 32'd0);
      repeat (2) @(posedge clk);
      #1;
      clr_n = 1'b1;
      seen = 1'b0;
      repeat (6) begin
         @(posedge clk); #1;
         if (rsp_valid) seen = 1'b1;
      end
      check("midrst_no_response", 32'(seen), 32'd0);
      check("midrst_ready_back", 32'(req_ready), 32'd1);
      do_txn(1'b0, 32'h20, 32'h0, 4'h0, 0, 1'b0, 32'd0, rd, er);
      check("midrst_old_value", rd, old_val);

      // Random traffic against the model
      for (int i = 0; i < 120; i++) begin
         we_r = 1'($urandom_range(0, 1));
         r = $urandom_range(0, 9);
         if (r < 8)       addr_r = 32'($urandom_range(0, DEPTH * 4 - 1));
         else if (r == 8) addr_r = 32'($urandom_range(DEPTH * 4, DEPTH * 8 - 1));
         else             addr_r = $urandom;
         wd_r = $urandom;
         be_r = 4'($urandom_range(0, 15));
         model_txn(we_r, addr_r, wd_r, be_r, exp_rd, exp_er);
         do_txn(we_r, addr_r, wd_r, be_r, $urandom_range(0, 2), (i % 10) == 0,
                32'($urandom_range(0, DEPTH * 4 - 1)), rd, er);
         check("rand_rdata", rd, exp_rd);
         check("rand_err", 32'(er), 32'(exp_er));
         // A stray store must not have landed: re-read a word after each one
         if ((i % 10) == 0) begin
            addr_r = 32'($urandom_range(0, DEPTH * 4 - 1));
            model_txn(1'b0, addr_r, 32'h0, 4'h0, exp_rd, exp_er);
            do_txn(1'b0, addr_r, 32'h0, 4'h0, 0, 1'b0, 32'd0, rd, er);
            check("rand_reread", rd, exp_rd);
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
